prf_busy_table_int: RTL and testbench
=====================================

Name: prf_busy_table_int

Overview:
Integer physical-register busy table and wakeup scheduler. It answers the integer issue queue's per-slot operand queries: the queue drives rs1/rs2 PRF indices and this block returns rs1/rs2 busy bits.
- Busy bits are set when rename/dispatch allocates a destination register.
- Busy bits are cleared by a latency-timed wakeup pipeline fed by issued uops, or by writeback for variable-latency units.
- The block sits between dispatch, the integer issue queue and the execution pipes.

Parameters:
PRF_INT_SIZE, 64, number of integer physical registers
PRF_INT_INDEX_SIZE, 6, log2(PRF_INT_SIZE)
IQ_INT_SIZE, 16, issue-queue slots queried per cycle
DISPATCH_WIDTH, 4, allocations per cycle
ISSUE_WIDTH_INT, 3, integer issue ports
WB_WIDTH, 3, writeback wake ports
MAX_LAT, 4, largest fixed latency scheduled by the wake pipeline
LAT_W, 3, width of the latency code, $clog2(MAX_LAT+1)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
flush  in  1  pipeline squash (mispredict/exception)
rs1_index  in  IQ_INT_SIZE x PRF_INT_INDEX_SIZE  per-slot rs1 query
rs2_index  in  IQ_INT_SIZE x PRF_INT_INDEX_SIZE  per-slot rs2 query
rs1_busy  out  IQ_INT_SIZE  per-slot rs1 busy
rs2_busy  out  IQ_INT_SIZE  per-slot rs2 busy
alloc_valid  in  DISPATCH_WIDTH  allocation strobe
alloc_index  in  DISPATCH_WIDTH x PRF_INT_INDEX_SIZE  allocated rd PRF index
issue_valid  in  ISSUE_WIDTH_INT  uop issued this cycle and writes rd
issue_index  in  ISSUE_WIDTH_INT x PRF_INT_INDEX_SIZE  issued uop rd index
issue_lat  in  ISSUE_WIDTH_INT x LAT_W  1..MAX_LAT = fixed latency; 0 = variable latency (wake via writeback)
wb_valid  in  WB_WIDTH  writeback wake strobe
wb_index  in  WB_WIDTH x PRF_INT_INDEX_SIZE  writeback rd index
busy_count  out  PRF_INT_INDEX_SIZE+1  registered popcount of the busy table (debug/stall heuristics)

Behaviour:
- State:
  - busy[PRF_INT_SIZE] flops.
  - Wake pipeline of MAX_LAT stages; each stage is a PRF_INT_SIZE-bit mask, stage[0..MAX_LAT-1].
- Reset (asynchronous): busy = 0, all stage masks = 0, busy_count = 0. Consequently rs1_busy = rs2_busy = 0 during reset.
- Masks formed each cycle:
  - alloc_mask = OR of onehot(alloc_index[i]) where alloc_valid[i].
  - wake_mask = stage[0] | OR of onehot(wb_index[j]) where wb_valid[j].
- Register update:
  - busy_next = (busy & ~wake_mask) | alloc_mask. Allocation wins over wake for the same index in the same cycle.
  - Entry 0 is forced to 0 in busy_next and in all stage masks (x0 / non-RF operands map to index 0 and are never busy).
- Query (combinational): rs*_busy[k] = busy_next[rs*_index[k]].
  - A consumer dispatched in the same group as its producer reads busy.
  - A consumer whose producer wakes this cycle reads not-busy.
- Wake pipeline:
  - Each cycle, stage[s] <= stage[s+1] for s < MAX_LAT-1, and stage[MAX_LAT-1] <= 0.
  - A valid issue on port p with issue_lat = L in 1..MAX_LAT ORs onehot(issue_index[p]) into the value loaded into stage[L-1].
  - Result: a producer issued in cycle N wakes in cycle N+L, so a dependent can issue in N+L.
  - Multiple ports targeting the same stage OR together; no conflict is possible.
  - issue_lat = 0, or issue_lat > MAX_LAT (illegal; assertion in sim), schedules nothing.
- busy_count <= popcount(busy_next), one-cycle latency.
- flush (synchronous, at the clock edge):
  - busy <= 0 and all stages <= 0; alloc/issue/wb inputs in the same cycle are ignored.
  - Queries in the flush cycle still return busy_next computed without the flush.
- Simultaneous events:
  - Alloc and wb on the same index: busy ends set.
  - Duplicate alloc indices in one cycle: tolerated (OR).
  - Wake of a non-busy index: no effect.
- Reset asserted mid-operation clears all state immediately, regardless of the clock.

Decomposition:
- Shared package (micro_op.svh side):
  - PRF_INT_SIZE, PRF_INT_INDEX_SIZE, IQ_INT_SIZE, DISPATCH_WIDTH, ISSUE_WIDTH_INT and MAX_LAT macros.
  - typedef for the issue latency code, with FU latencies defined there: ALU 1, IMUL 3, IDIV 0 (variable), BR 1.
- One natural sub-module: prf_wake_pipe_int, the MAX_LAT-stage mask shift pipeline with injection.

Test Plan:
1. Reset, then query rs1_index[0]=5, rs2_index[0]=0 -> rs1_busy[0]=0, rs2_busy[0]=0, busy_count=0.
2. alloc index 7 in cycle 1 with rs1_index[3]=7 in the same cycle -> rs1_busy[3]=1 in cycle 1; busy_count=1 in cycle 2.
3. After test 2, issue index 7 with lat=1 in cycle 4 -> rs1_busy[3]=1 in cycle 4, 0 in cycle 5; with lat=3 on port 1 instead -> 0 first in cycle 7.
4. alloc 9, issue 9 with lat=0, wb index 9 in cycle 10 -> busy through cycle 9, not busy in cycle 10. Then alloc 9 and wb 9 together in cycle 12 -> busy stays 1.
5. alloc 0 and query 0 -> always 0. Allocate 4 distinct indices in one cycle, then flush -> all queries 0 next cycle, busy_count=0, and the pending lat=4 wake does not re-clear later allocations.
6. Assert reset asynchronously mid-cycle while 10 entries are busy -> all busy outputs and busy_count drop to 0 before the next edge.

Source files
------------

// File: rtl/prf_busy_table_int_pkg.sv
// Integer PRF sizing, issue-latency codes and mask helpers shared by the busy table and its wake pipe.
// Latencies are in cycles from issue to dependent-issue; 0 means the unit wakes its rd via writeback.
package prf_busy_table_int_pkg;

  localparam int PRF_INT_SIZE       = 64;
  localparam int PRF_INT_INDEX_SIZE = 6;
  localparam int IQ_INT_SIZE        = 16;
  localparam int DISPATCH_WIDTH     = 4;
  localparam int ISSUE_WIDTH_INT    = 3;
  localparam int WB_WIDTH           = 3;
  localparam int MAX_LAT            = 4;
  localparam int LAT_W              = $clog2(MAX_LAT + 1);

  typedef logic [LAT_W-1:0]              lat_t;
  typedef logic [PRF_INT_SIZE-1:0]       prf_mask_t;
  typedef logic [PRF_INT_INDEX_SIZE-1:0] prf_idx_t;
  typedef logic [PRF_INT_INDEX_SIZE:0]   busy_cnt_t;

  localparam lat_t LAT_ALU  = lat_t'(1);
  localparam lat_t LAT_IMUL = lat_t'(3);
  localparam lat_t LAT_IDIV = lat_t'(0);
  localparam lat_t LAT_BR   = lat_t'(1);

  function automatic busy_cnt_t popcount(input prf_mask_t m);
    busy_cnt_t c;
    c = '0;
    for (int i = 0; i < PRF_INT_SIZE; i++) c = c + busy_cnt_t'(m[i]);
    return c;
  endfunction

endpackage

// File: rtl/prf_wake_pipe_int.sv
// MAX_LAT-stage shift pipeline of PRF wake masks; an issue with latency L lands in stage L-1.
// Stage 0 is the wake due this cycle; no backpressure, flush empties every stage.
module prf_wake_pipe_int
  import prf_busy_table_int_pkg::*;
(
  input  logic                                              clock,
  input  logic                                              reset,
  input  logic                                              flush,
  input  logic      [ISSUE_WIDTH_INT-1:0]                   issue_valid,
  input  prf_idx_t  [ISSUE_WIDTH_INT-1:0]                   issue_index,
  input  lat_t      [ISSUE_WIDTH_INT-1:0]                   issue_lat,
  output prf_mask_t                                         wake_due
);

  prf_mask_t [MAX_LAT-1:0] stage_q;
  prf_mask_t [MAX_LAT-1:0] stage_d;

  always_comb begin
    stage_d = '0;
    for (int s = 0; s < MAX_LAT - 1; s++) stage_d[s] = stage_q[s+1];
    // Latency 0 and out-of-range codes match no stage, so they schedule nothing.
    for (int p = 0; p < ISSUE_WIDTH_INT; p++) begin
      for (int s = 0; s < MAX_LAT; s++) begin
        if (issue_valid[p] && issue_lat[p] == lat_t'(s + 1)) stage_d[s][issue_index[p]] = 1'b1;
      end
    end
    for (int s = 0; s < MAX_LAT; s++) stage_d[s][0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      stage_q <= '0;
    else if (flush) stage_q <= '0;
    else            stage_q <= stage_d;
  end

  assign wake_due = stage_q[0];

  for (genvar p = 0; p < ISSUE_WIDTH_INT; p++) begin : g_lat_chk
    lat_legal: assert property (@(posedge clock) disable iff (reset)
      !issue_valid[p] || issue_lat[p] <= lat_t'(MAX_LAT));
  end

endmodule

// File: rtl/prf_busy_table_int.sv
// Integer PRF busy table: set on allocation, cleared by timed wake or writeback; queries see same-cycle updates.
// Queries are combinational on busy_next, busy_count lags one cycle; no backpressure, flush clears all state.
module prf_busy_table_int
  import prf_busy_table_int_pkg::*;
(
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                flush,
  input  prf_idx_t  [IQ_INT_SIZE-1:0]         rs1_index,
  input  prf_idx_t  [IQ_INT_SIZE-1:0]         rs2_index,
  output logic      [IQ_INT_SIZE-1:0]         rs1_busy,
  output logic      [IQ_INT_SIZE-1:0]         rs2_busy,
  input  logic      [DISPATCH_WIDTH-1:0]      alloc_valid,
  input  prf_idx_t  [DISPATCH_WIDTH-1:0]      alloc_index,
  input  logic      [ISSUE_WIDTH_INT-1:0]     issue_valid,
  input  prf_idx_t  [ISSUE_WIDTH_INT-1:0]     issue_index,
  input  lat_t      [ISSUE_WIDTH_INT-1:0]     issue_lat,
  input  logic      [WB_WIDTH-1:0]            wb_valid,
  input  prf_idx_t  [WB_WIDTH-1:0]            wb_index,
  output busy_cnt_t                           busy_count
);

  prf_mask_t busy_q;
  prf_mask_t busy_next;
  prf_mask_t alloc_mask;
  prf_mask_t wake_mask;
  prf_mask_t wake_due;

  prf_wake_pipe_int u_wake_pipe (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .issue_valid (issue_valid),
    .issue_index (issue_index),
    .issue_lat   (issue_lat),
    .wake_due    (wake_due)
  );

  always_comb begin
    alloc_mask = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      if (alloc_valid[i]) alloc_mask[alloc_index[i]] = 1'b1;
    end
    wake_mask = wake_due;
    for (int j = 0; j < WB_WIDTH; j++) begin
      if (wb_valid[j]) wake_mask[wb_index[j]] = 1'b1;
    end
    // Allocation overrides a same-cycle wake of the same register.
    busy_next    = (busy_q & ~wake_mask) | alloc_mask;
    busy_next[0] = 1'b0;
    if (reset) busy_next = '0;
  end

  always_comb begin
    rs1_busy = '0;
    rs2_busy = '0;
    for (int k = 0; k < IQ_INT_SIZE; k++) begin
      rs1_busy[k] = busy_next[rs1_index[k]];
      rs2_busy[k] = busy_next[rs2_index[k]];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q     <= '0;
      busy_count <= '0;
    end else if (flush) begin
      busy_q     <= '0;
      busy_count <= '0;
    end else begin
      busy_q     <= busy_next;
      busy_count <= popcount(busy_next);
    end
  end

endmodule

// File: tb/tb_prf_busy_table_int.sv
// Directed bench for the integer busy table: alloc, timed wake, writeback wake, flush and async reset.
module tb_prf_busy_table_int;
  import prf_busy_table_int_pkg::*;

  logic                               clock;
  logic                               reset;
  logic                               flush;
  prf_idx_t  [IQ_INT_SIZE-1:0]        rs1_index;
  prf_idx_t  [IQ_INT_SIZE-1:0]        rs2_index;
  logic      [IQ_INT_SIZE-1:0]        rs1_busy;
  logic      [IQ_INT_SIZE-1:0]        rs2_busy;
  logic      [DISPATCH_WIDTH-1:0]     alloc_valid;
  prf_idx_t  [DISPATCH_WIDTH-1:0]     alloc_index;
  logic      [ISSUE_WIDTH_INT-1:0]    issue_valid;
  prf_idx_t  [ISSUE_WIDTH_INT-1:0]    issue_index;
  lat_t      [ISSUE_WIDTH_INT-1:0]    issue_lat;
  logic      [WB_WIDTH-1:0]           wb_valid;
  prf_idx_t  [WB_WIDTH-1:0]           wb_index;
  busy_cnt_t                          busy_count;

  int checks = 0;
  int errors = 0;

  prf_busy_table_int dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .rs1_index   (rs1_index),
    .rs2_index   (rs2_index),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .alloc_valid (alloc_valid),
    .alloc_index (alloc_index),
    .issue_valid (issue_valid),
    .issue_index (issue_index),
    .issue_lat   (issue_lat),
    .wb_valid    (wb_valid),
    .wb_index    (wb_index),
    .busy_count  (busy_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    flush       = 1'b0;
    alloc_valid = '0;
    alloc_index = '0;
    issue_valid = '0;
    issue_index = '0;
    issue_lat   = '0;
    wb_valid    = '0;
    wb_index    = '0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic next_cycle();
    @(posedge clock);
    #1;
    idle();
  endtask

  initial begin
    reset     = 1'b1;
    rs1_index = '0;
    rs2_index = '0;
    idle();
    #3;
    chk("in_reset_rs1", 32'(rs1_busy), 0);
    chk("in_reset_count", 32'(busy_count), 0);
    #9;
    reset = 1'b0;

    // Reset state queries
    next_cycle();
    rs1_index[0] = 6'd5;
    rs2_index[0] = 6'd0;
    #2;
    chk("reset_rs1_q5", 32'(rs1_busy[0]), 1'b0);
    chk("reset_rs2_q0", 32'(rs2_busy[0]), 1'b0);
    chk("reset_count", 32'(busy_count), 0);

    // Same-group allocation is visible to the query
    next_cycle();
    rs1_index[3]   = 6'd7;
    alloc_valid[0] = 1'b1;
    alloc_index[0] = 6'd7;
    #2;
    chk("alloc7_same_cycle", 32'(rs1_busy[3]), 1);
    next_cycle();
    #2;
    chk("alloc7_count", 32'(busy_count), 1);
    chk("alloc7_held", 32'(rs1_busy[3]), 1);

    // Latency-1 wake
    next_cycle();
    issue_valid[0] = 1'b1;
    issue_index[0] = 6'd7;
    issue_lat[0]   = LAT_ALU;
    #2;
    chk("lat1_issue_cycle", 32'(rs1_busy[3]), 1);
    next_cycle();
    #2;
    chk("lat1_wake", 32'(rs1_busy[3]), 0);
    next_cycle();
    #2;
    chk("lat1_count", 32'(busy_count), 0);

    // Latency-3 wake on port 1
    next_cycle();
    alloc_valid[1] = 1'b1;
    alloc_index[1] = 6'd7;
    next_cycle();
    issue_valid[1] = 1'b1;
    issue_index[1] = 6'd7;
    issue_lat[1]   = LAT_IMUL;
    #2;
    chk("lat3_n0", 32'(rs1_busy[3]), 1);
    next_cycle();
    #2;
    chk("lat3_n1", 32'(rs1_busy[3]), 1);
    next_cycle();
    #2;
    chk("lat3_n2", 32'(rs1_busy[3]), 1);
    next_cycle();
    #2;
    chk("lat3_wake", 32'(rs1_busy[3]), 0);

    // Variable latency: issue with lat 0 schedules nothing, writeback wakes
    next_cycle();
    rs2_index[5]   = 6'd9;
    alloc_valid[2] = 1'b1;
    alloc_index[2] = 6'd9;
    #2;
    chk("alloc9", 32'(rs2_busy[5]), 1);
    next_cycle();
    issue_valid[2] = 1'b1;
    issue_index[2] = 6'd9;
    issue_lat[2]   = LAT_IDIV;
    #2;
    chk("lat0_issue", 32'(rs2_busy[5]), 1);
    next_cycle();
    #2;
    chk("lat0_no_wake_a", 32'(rs2_busy[5]), 1);
    next_cycle();
    #2;
    chk("lat0_no_wake_b", 32'(rs2_busy[5]), 1);
    next_cycle();
    wb_valid[0] = 1'b1;
    wb_index[0] = 6'd9;
    #2;
    chk("wb_wake", 32'(rs2_busy[5]), 0);
    next_cycle();
    #2;
    chk("wb_after", 32'(rs2_busy[5]), 0);
    chk("wb_count", 32'(busy_count), 0);

    // Alloc and writeback on the same index: allocation wins
    next_cycle();
    alloc_valid[0] = 1'b1;
    alloc_index[0] = 6'd9;
    wb_valid[1]    = 1'b1;
    wb_index[1]    = 6'd9;
    #2;
    chk("alloc_wb_same", 32'(rs2_busy[5]), 1);
    next_cycle();
    #2;
    chk("alloc_wb_held", 32'(rs2_busy[5]), 1);
    chk("alloc_wb_count", 32'(busy_count), 1);

    // Register 0 is never busy
    next_cycle();
    alloc_valid[0] = 1'b1;
    alloc_index[0] = 6'd0;
    rs1_index[0]   = 6'd0;
    #2;
    chk("x0_same_cycle", 32'(rs1_busy[0]), 0);
    next_cycle();
    #2;
    chk("x0_next", 32'(rs1_busy[0]), 0);
    chk("x0_count", 32'(busy_count), 1);

    // Four allocations, a pending lat-4 wake, then flush
    next_cycle();
    alloc_valid  = 4'b1111;
    alloc_index  = {6'd13, 6'd12, 6'd11, 6'd10};
    rs1_index[1] = 6'd10;
    rs1_index[2] = 6'd13;
    #2;
    chk("alloc4_q10", 32'(rs1_busy[1]), 1);
    chk("alloc4_q13", 32'(rs1_busy[2]), 1);
    next_cycle();
    issue_valid[0] = 1'b1;
    issue_index[0] = 6'd10;
    issue_lat[0]   = lat_t'(4);
    #2;
    chk("alloc4_count", 32'(busy_count), 5);
    next_cycle();
    flush          = 1'b1;
    alloc_valid[0] = 1'b1;
    alloc_index[0] = 6'd20;
    wb_valid[0]    = 1'b1;
    wb_index[0]    = 6'd11;
    rs1_index[2]   = 6'd20;
    #2;
    chk("flush_cycle_q10", 32'(rs1_busy[1]), 1);
    chk("flush_cycle_q20", 32'(rs1_busy[2]), 1);
    next_cycle();
    #2;
    chk("post_flush_q10", 32'(rs1_busy[1]), 0);
    chk("post_flush_q20", 32'(rs1_busy[2]), 0);
    chk("post_flush_count", 32'(busy_count), 0);
    next_cycle();
    alloc_valid[3] = 1'b1;
    alloc_index[3] = 6'd10;
    #2;
    chk("realloc10", 32'(rs1_busy[1]), 1);
    next_cycle();
    #2;
    chk("stale_wake_slot", 32'(rs1_busy[1]), 1);
    next_cycle();
    #2;
    chk("stale_wake_after", 32'(rs1_busy[1]), 1);
    chk("realloc_count", 32'(busy_count), 1);

    // Build up ten busy entries, then reset asynchronously mid-cycle
    next_cycle();
    alloc_valid = 4'b1111;
    alloc_index = {6'd24, 6'd23, 6'd22, 6'd21};
    next_cycle();
    alloc_valid = 4'b1111;
    alloc_index = {6'd28, 6'd27, 6'd26, 6'd25};
    next_cycle();
    alloc_valid[0] = 1'b1;
    alloc_index[0] = 6'd29;
    next_cycle();
    rs1_index[4] = 6'd21;
    rs2_index[4] = 6'd29;
    #2;
    chk("ten_busy_count", 32'(busy_count), 10);
    chk("ten_busy_q21", 32'(rs1_busy[4]), 1);
    chk("ten_busy_q29", 32'(rs2_busy[4]), 1);
    reset = 1'b1;
    #1;
    chk("async_rst_q21", 32'(rs1_busy[4]), 0);
    chk("async_rst_q29", 32'(rs2_busy[4]), 0);
    chk("async_rst_count", 32'(busy_count), 0);
    #2;
    reset = 1'b0;
    next_cycle();
    #2;
    chk("post_rst_q21", 32'(rs1_busy[4]), 0);
    chk("post_rst_count", 32'(busy_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
